// File: rtl/mmc_control.sv
// mmc_control: multi-cycle sequencer for the 16-bit mini-MIPS datapath.
// It fetches through an ack handshake, decodes, executes, and writes back,
// sharing the single ALU between the PC+2 increment and the instruction.
// It halts on an illegal opcode or a fetch timeout and counts retired
// instructions.
// Optional feature macro: MMC_SINGLE_STEP_EN. When it is defined, the block
// gains a `step` input and a STEP state, so it retires one instruction per
// step pulse.
module mmc_control #(
  parameter int CNT_W         = 16,
  parameter int FETCH_TIMEOUT = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             run,
`ifdef MMC_SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic [3:0]       op,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             pc_write,
  output logic             ir_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_ctl,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             halted,
  output logic [1:0]       error,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  // The wait counter only has to reach FETCH_TIMEOUT-1.
  localparam int WAIT_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(FETCH_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_STEP   = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [3:0]        op_q, op_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [1:0]        error_q, error_d;

  // ALU operation for the opcode held in op_q.
  function automatic logic [3:0] alu_op(input logic [3:0] o);
    case (o)
      4'd0:    return 4'b0010;
      4'd1:    return 4'b0110;
      4'd2:    return 4'b0000;
      4'd3:    return 4'b0001;
      4'd4:    return 4'b1100;
      4'd5:    return 4'b1101;
      4'd6:    return 4'b0111;
      default: return 4'b0010;
    endcase
  endfunction

  // State register with the sequencer bookkeeping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      op_q      <= '0;
      retired_q <= '0;
      error_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments let every register sample the
      // pre-edge values, regardless of the statement order.
      state_q   <= state_d;
      wait_q    <= wait_d;
      op_q      <= op_d;
      retired_q <= retired_d;
      error_q   <= error_d;
    end
  end

  // Next-state logic and strobe decode. The outputs come from the state,
  // so they all drop to 0 as soon as reset_n goes low.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case
    // leaves one unassigned (which would infer a latch).
    state_d   = state_q;
    wait_d    = wait_q;
    op_d      = op_q;
    retired_d = retired_q;
    error_d   = error_q;
    imem_req  = 1'b0;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    alu_ctl   = 4'b0000;
    reg_dst   = 1'b0;
    reg_write = 1'b0;
    halted    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end

      S_FETCH: begin
        // The ALU computes PC + 2 while the fetch is outstanding.
        imem_req  = 1'b1;
        alu_src_b = 2'b01;
        alu_ctl   = 4'b0010;
        if (imem_ack) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          wait_d   = '0;
          state_d  = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          error_d[1] = 1'b1;
          state_d    = S_HALT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_DECODE: begin
        op_d = op;
        if (op[3]) begin
          error_d[0] = 1'b1;
          state_d    = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = (op_q == 4'd7) ? 2'b10 : 2'b00;
        alu_ctl   = alu_op(op_q);
        state_d   = S_WB;
      end

      S_WB: begin
        // The ALU selects are held from EXEC so the result stays stable
        // while the register file writes it.
        alu_src_a = 1'b1;
        alu_src_b = (op_q == 4'd7) ? 2'b10 : 2'b00;
        alu_ctl   = alu_op(op_q);
        reg_write = 1'b1;
        reg_dst   = (op_q != 4'd7);
        retired_d = retired_q + CNT_W'(1);
`ifdef MMC_SINGLE_STEP_EN
        state_d   = run ? S_STEP : S_IDLE;
`else
        state_d   = run ? S_FETCH : S_IDLE;
`endif
      end

      S_HALT: begin
        halted = 1'b1;
      end

`ifdef MMC_SINGLE_STEP_EN
      S_STEP: begin
        // Dropping run takes priority over a step pulse.
        if (!run)      state_d = S_IDLE;
        else if (step) state_d = S_FETCH;
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  assign error   = error_q;
  assign retired = retired_q;
  assign state   = state_q;

endmodule

// File: tb/tb_mmc_control.sv
// tb_mmc_control: directed and randomized instruction sequences for
// mmc_control. Expected per-cycle outputs come from an instruction-level
// schedule: stall cycles, then fetch, decode, exec and writeback.
// The bench instantiates the block with CNT_W=4, so the retired counter
// wraps within the run.
module tb_mmc_control;

  localparam int CNT_W = 4;
  localparam int FT    = 8;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             run;
  logic             imem_ack;
  logic [3:0]       op;
`ifdef MMC_SINGLE_STEP_EN
  logic             step;
`endif
  logic             imem_req, pc_write, ir_write, alu_src_a, reg_dst;
  logic             reg_write, halted;
  logic [1:0]       alu_src_b, error;
  logic [3:0]       alu_ctl;
  logic [CNT_W-1:0] retired;
  logic [2:0]       state;

  mmc_control #(.CNT_W(CNT_W), .FETCH_TIMEOUT(FT)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .run       (run),
`ifdef MMC_SINGLE_STEP_EN
    .step      (step),
`endif
    .op        (op),
    .imem_req  (imem_req),
    .imem_ack  (imem_ack),
    .pc_write  (pc_write),
    .ir_write  (ir_write),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .alu_ctl   (alu_ctl),
    .reg_dst   (reg_dst),
    .reg_write (reg_write),
    .halted    (halted),
    .error     (error),
    .retired   (retired),
    .state     (state)
  );

  always #5 clock = ~clock;

  logic [15:0] obs_vec;
  assign obs_vec = {state, halted, imem_req, pc_write, ir_write, alu_src_a,
                    alu_src_b, alu_ctl, reg_dst, reg_write};

  int               n_cmp = 0;
  int               n_bad = 0;
  logic [CNT_W-1:0] model_retired;
  logic [1:0]       model_err;
  bit               at_idle;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Published ALU code table, indexed by opcode.
  function automatic logic [3:0] alu_tbl(input logic [3:0] o);
    logic [3:0] t [8] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001,
                          4'b1100, 4'b1101, 4'b0111, 4'b0010};
    return t[o[2:0]];
  endfunction

  // Expected output vector for a phase (0..6), the fetch ack, and the
  // opcode of the instruction in flight.
  function automatic logic [15:0] pack_exp(input int st, input logic ack, input logic [3:0] oq);
    logic       req = 0, pw = 0, iw = 0, a = 0, dst = 0, rw = 0, h = 0;
    logic [1:0] b = 0;
    logic [3:0] c = 0;
    logic [2:0] s3 = 3'(st);
    if (st == 1) begin
      req = 1; b = 2'b01; c = 4'b0010; pw = ack; iw = ack;
    end else if (st == 3 || st == 4) begin
      a = 1;
      b = (oq == 4'd7) ? 2'b10 : 2'b00;
      c = alu_tbl(oq);
      if (st == 4) begin
        rw  = 1;
        dst = (oq != 4'd7);
      end
    end else if (st == 5) begin
      h = 1;
    end
    return {s3, h, req, pw, iw, a, b, c, dst, rw};
  endfunction

  function automatic logic [3:0] junk();
    return 4'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  // Drive one cycle at the falling edge, then check the outputs 1 ns later.
  task automatic cyc(input string tag, input logic r, input logic a, input logic [3:0] o,
                     input logic s, input int st, input logic [3:0] oq);
    @(negedge clock);
    run = r; imem_ack = a; op = o;
`ifdef MMC_SINGLE_STEP_EN
    step = s;
`else
    if (s) $display("note: step ignored in this build");
`endif
    #1;
    check({tag, "/outs"}, 32'(obs_vec), 32'(pack_exp(st, a, oq)));
    check({tag, "/retired"}, 32'(retired), 32'(model_retired));
    check({tag, "/error"}, 32'(error), 32'(model_err));
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0; run = 1'b0; imem_ack = 1'b0; op = 4'd0;
`ifdef MMC_SINGLE_STEP_EN
    step = 1'b0;
`endif
    model_retired = '0; model_err = 2'b00; at_idle = 1'b1;
    #1;
    check("reset/outs", 32'(obs_vec), 32'(0));
    check("reset/retired", 32'(retired), 32'(0));
    check("reset/error", 32'(error), 32'(0));
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Wait in STEP for n cycles, then pulse step to start the next fetch.
  task automatic step_wait(input int n);
    for (int i = 0; i < n; i++) cyc("step_hold", 1'b1, rbit(), junk(), 1'b0, 6, 4'd0);
    cyc("step_go", 1'b1, rbit(), junk(), 1'b1, 6, 4'd0);
  endtask

  // Run one instruction: optional idle entry, `stall` unacked fetch cycles,
  // then the acked fetch, decode, and either exec/wb or HALT.
  task automatic do_instr(input logic [3:0] opv, input int stall, input logic run_end);
    if (at_idle) begin
      if (rbit()) cyc("idle_hold", 1'b0, rbit(), junk(), 1'b0, 0, 4'd0);
      cyc("idle_go", 1'b1, rbit(), junk(), 1'b0, 0, 4'd0);
      at_idle = 1'b0;
    end
    for (int i = 0; i < stall; i++) cyc("fetch_wait", rbit(), 1'b0, junk(), 1'b0, 1, 4'd0);
    cyc("fetch_ack", rbit(), 1'b1, junk(), 1'b0, 1, 4'd0);
    cyc("decode", rbit(), rbit(), opv, 1'b0, 2, 4'd0);
    if (opv[3]) begin
      model_err[0] = 1'b1;
      cyc("illegal_halt", rbit(), rbit(), junk(), 1'b0, 5, 4'd0);
      return;
    end
    cyc("exec", rbit(), rbit(), junk(), 1'b0, 3, opv);
    cyc("wb", run_end, rbit(), junk(), 1'b0, 4, opv);
    model_retired = model_retired + 1'b1;
    if (!run_end) at_idle = 1'b1;
`ifdef MMC_SINGLE_STEP_EN
    else step_wait(int'($urandom_range(0, 2)));
`endif
  endtask

  initial begin
    reset_n = 1'b0; run = 1'b0; imem_ack = 1'b0; op = 4'd0;
`ifdef MMC_SINGLE_STEP_EN
    step = 1'b0;
`endif
    model_retired = '0; model_err = 2'b00; at_idle = 1'b1;

    // Fast run: ops 7, 7, 2 with no stalls.
    do_reset();
    do_instr(4'd7, 0, 1'b1);
    do_instr(4'd7, 0, 1'b1);
    do_instr(4'd2, 0, 1'b0);
    cyc("fast_idle", 1'b0, 1'b0, 4'd0, 1'b0, 0, 4'd0);
    check("fast_retired3", 32'(retired), 32'(3));

    // Fetch stall: ack arrives on the 4th fetch cycle. Then a boundary case
    // with FT-1 stall cycles, which must not time out.
    do_instr(4'd4, 3, 1'b1);
    do_instr(4'd5, FT - 1, 1'b0);

    // Reset during EXEC of op 1.
    cyc("rst_idle", 1'b1, 1'b0, 4'd0, 1'b0, 0, 4'd0);
    cyc("rst_fetch", 1'b1, 1'b1, 4'd0, 1'b0, 1, 4'd0);
    cyc("rst_decode", 1'b1, 1'b0, 4'd1, 1'b0, 2, 4'd0);
    cyc("rst_exec", 1'b1, 1'b0, 4'd1, 1'b0, 3, 4'd1);
    #2 reset_n = 1'b0;
    model_retired = '0; model_err = 2'b00;
    #1;
    check("midrst/outs", 32'(obs_vec), 32'(0));
    check("midrst/retired", 32'(retired), 32'(0));
    @(negedge clock);
    reset_n = 1'b1; run = 1'b1;
    #1;
    check("midrst/release_idle", 32'(state), 32'(0));
    at_idle = 1'b0;
    do_instr(4'd6, 0, 1'b0);

    // Timeout: ack held low for FT fetch cycles, then HALT.
    do_reset();
    cyc("to_idle", 1'b1, 1'b0, 4'd0, 1'b0, 0, 4'd0);
    for (int i = 0; i < FT; i++) cyc("to_fetch", 1'b1, 1'b0, junk(), 1'b0, 1, 4'd0);
    model_err[1] = 1'b1;
    for (int i = 0; i < 4; i++) cyc("to_halt", 1'(i), rbit(), junk(), 1'b0, 5, 4'd0);
    check("to_error10", 32'(error), 32'(2));

    // Illegal opcode after one legal instruction.
    do_reset();
    do_instr(4'd3, 0, 1'b1);
    do_instr(4'b1010, 1, 1'b1);
    for (int i = 0; i < 3; i++) cyc("ill_halt", rbit(), rbit(), junk(), 1'b0, 5, 4'd0);
    check("ill_error01", 32'(error), 32'(1));
    check("ill_retired1", 32'(retired), 32'(1));

    // Randomized legal instructions; the 4-bit retired counter wraps.
    do_reset();
    for (int n = 0; n < 40; n++)
      do_instr(4'($urandom_range(0, 7)), int'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));

`ifdef MMC_SINGLE_STEP_EN
    // Single step: one step pulse per 10 cycles, then run=0 in STEP.
    do_reset();
    do_instr(4'd0, 0, 1'b1);   // this ends with a random step_wait
    for (int n = 0; n < 3; n++) begin
      cyc("ss_fetch", 1'b1, 1'b1, 4'd0, 1'b0, 1, 4'd0);
      cyc("ss_decode", 1'b1, 1'b0, 4'd1, 1'b0, 2, 4'd0);
      cyc("ss_exec", 1'b1, 1'b0, 4'd0, 1'b0, 3, 4'd1);
      cyc("ss_wb", 1'b1, 1'b0, 4'd0, 1'b0, 4, 4'd1);
      model_retired = model_retired + 1'b1;
      step_wait(5);
    end
    cyc("ss_fetch", 1'b1, 1'b1, 4'd0, 1'b0, 1, 4'd0);
    cyc("ss_decode", 1'b1, 1'b0, 4'd2, 1'b0, 2, 4'd0);
    cyc("ss_exec", 1'b1, 1'b0, 4'd0, 1'b0, 3, 4'd2);
    cyc("ss_wb", 1'b1, 1'b0, 4'd0, 1'b0, 4, 4'd2);
    model_retired = model_retired + 1'b1;
    cyc("ss_stop", 1'b0, 1'b0, 4'd0, 1'b1, 6, 4'd0);
    cyc("ss_idle", 1'b0, 1'b0, 4'd0, 1'b0, 0, 4'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
